// File: rtl/retire_trace_buf.sv
// rtl/retire_trace_buf.sv - retired-instruction trace FIFO with stop-when-full / wrap capture modes
module retire_trace_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              arm,
  input  logic              mode,
  input  logic              retire_valid,
  input  logic [DATA_W-1:0] retire_pc,
  input  logic [DATA_W-1:0] retire_ins,
  input  logic [DATA_W-1:0] retire_res,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_ins,
  output logic [DATA_W-1:0] rd_res,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic [DATA_W-1:0] dropped,
  output logic              wrapped
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_pc  [DEPTH];
  logic [DATA_W-1:0] mem_ins [DEPTH];
  logic [DATA_W-1:0] mem_res [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  logic we;
  logic re;
  logic store;
  logic lost;
  logic overwrite;

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_FULL);

  assign we = retire_valid & arm;
  assign re = rd_req & ~empty;
  // A write into a full buffer with no concurrent pop loses a record: either
  // the new one (stop mode) or the oldest one (wrap mode).
  assign lost      = we & full & ~re;
  assign overwrite = lost & mode;
  assign store     = we & (~full | re | mode);

  always_ff @(posedge clk) begin
    if (reset && !clear && store) begin
      mem_pc[wr_ptr]  <= retire_pc;
      mem_ins[wr_ptr] <= retire_ins;
      mem_res[wr_ptr] <= retire_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      dropped  <= '0;
      wrapped  <= 1'b0;
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_ins   <= '0;
      rd_res   <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      dropped  <= '0;
      wrapped  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= re;
      if (re) begin
        rd_pc  <= mem_pc[rd_ptr];
        rd_ins <= mem_ins[rd_ptr];
        rd_res <= mem_res[rd_ptr];
      end
      if (store) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (re || overwrite) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (we && !re && !full) begin
        cnt <= cnt + CNT_ONE;
      end else if (re && !we) begin
        cnt <= cnt - CNT_ONE;
      end
      if (lost && (dropped != '1)) begin
        dropped <= dropped + DATA_W'(1);
      end
      if (overwrite) begin
        wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_retire_trace_buf.sv
// tb/tb_retire_trace_buf.sv - directed and random checks of retire_trace_buf against a queue model
module tb_retire_trace_buf;

  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          arm = 1'b0;
  logic          mode = 1'b0;
  logic          retire_valid = 1'b0;
  logic [DW-1:0] retire_pc = '0;
  logic [DW-1:0] retire_ins = '0;
  logic [DW-1:0] retire_res = '0;
  logic          rd_req = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_pc;
  logic [DW-1:0] rd_ins;
  logic [DW-1:0] rd_res;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic [DW-1:0] dropped;
  logic          wrapped;

  retire_trace_buf #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .arm(arm), .mode(mode),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_ins(retire_ins),
    .retire_res(retire_res), .rd_req(rd_req), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_ins(rd_ins), .rd_res(rd_res), .count(count), .empty(empty), .full(full),
    .dropped(dropped), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Reference: the trace is simply an ordered list of {pc,ins,res} records.
  logic [3*DW-1:0] q[$];
  int              m_dropped = 0;
  logic            m_wrapped = 1'b0;
  logic            m_rv = 1'b0;
  logic [3*DW-1:0] m_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [3*DW-1:0] rec;
    logic wr;
    logic rd;
    rec = {retire_pc, retire_ins, retire_res};
    if (!reset) begin
      q.delete(); m_dropped = 0; m_wrapped = 1'b0; m_rv = 1'b0; m_rd = '0;
    end else if (clear) begin
      q.delete(); m_dropped = 0; m_wrapped = 1'b0; m_rv = 1'b0;
    end else begin
      wr = retire_valid && arm;
      rd = rd_req && (q.size() > 0);
      m_rv = rd;
      if (rd) m_rd = q.pop_front();
      if (wr) begin
        if (q.size() < DEPTH) begin
          q.push_back(rec);
        end else begin
          if (m_dropped < (1 << DW) - 1) m_dropped++;
          if (mode) begin
            void'(q.pop_front());
            q.push_back(rec);
            m_wrapped = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("dropped", 32'(dropped), 32'(m_dropped));
    check("wrapped", 32'(wrapped), 32'(m_wrapped));
    check("rd_valid", 32'(rd_valid), 32'(m_rv));
    check("rd_pc", 32'(rd_pc), 32'(m_rd[3*DW-1:2*DW]));
    check("rd_ins", 32'(rd_ins), 32'(m_rd[2*DW-1:DW]));
    check("rd_res", 32'(rd_res), 32'(m_rd[DW-1:0]));
  endtask

  task automatic cyc(input logic rv, input logic [DW-1:0] pc, input logic rq);
    retire_valid = rv;
    retire_pc    = pc;
    retire_ins   = pc ^ 16'hA5A5;
    retire_res   = pc + 16'h0100;
    rd_req       = rq;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1'b0, '0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);

    // In-order pops, one cycle latency
    arm = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 3; i++) cyc(1'b1, 16'(i), 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("seq_pc", 32'(rd_pc), 32'(i));
    end
    cyc(1'b0, '0, 1'b0);
    check("seq_empty", 32'(empty), 32'd1);
    check("seq_rv_low", 32'(rd_valid), 32'd0);

    // Stop-when-full
    do_reset(); arm = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 6; i++) cyc(1'b1, 16'(i), 1'b0);
    check("stop_count", 32'(count), 32'd4);
    check("stop_dropped", 32'(dropped), 32'd2);
    check("stop_wrapped", 32'(wrapped), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("stop_pc", 32'(rd_pc), 32'(i));
    end

    // Wrap mode
    do_reset(); arm = 1'b1; mode = 1'b1;
    for (int i = 1; i <= 6; i++) cyc(1'b1, 16'(i), 1'b0);
    check("wrap_count", 32'(count), 32'd4);
    check("wrap_dropped", 32'(dropped), 32'd2);
    check("wrap_wrapped", 32'(wrapped), 32'd1);
    for (int i = 3; i <= 6; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("wrap_pc", 32'(rd_pc), 32'(i));
    end

    // Simultaneous write and read while full
    do_reset(); arm = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i), 1'b0);
    cyc(1'b1, 16'd9, 1'b1);
    check("wr_rd_full_pc", 32'(rd_pc), 32'd1);
    check("wr_rd_full_count", 32'(count), 32'd4);
    check("wr_rd_full_dropped", 32'(dropped), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("wr_rd_full_seq", 32'(rd_pc), (i == 3) ? 32'd9 : 32'(i + 2));
    end

    // Write and read on empty: write wins
    cyc(1'b1, 16'd7, 1'b1);
    check("wr_rd_empty_count", 32'(count), 32'd1);
    check("wr_rd_empty_rv", 32'(rd_valid), 32'd0);

    // Clear beats a concurrent write
    do_reset(); arm = 1'b1;
    for (int i = 1; i <= 3; i++) cyc(1'b1, 16'(i), 1'b0);
    clear = 1'b1;
    cyc(1'b1, 16'd5, 1'b0);
    clear = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    cyc(1'b0, '0, 1'b1);
    check("clr_pop_rv", 32'(rd_valid), 32'd0);

    // Reset abandons an in-flight read; disarmed retires are ignored
    cyc(1'b1, 16'd3, 1'b0);
    cyc(1'b0, '0, 1'b1);
    reset = 1'b0;
    cyc(1'b0, '0, 1'b0);
    reset = 1'b1;
    check("rst_inflight_rv", 32'(rd_valid), 32'd0);
    check("rst_inflight_count", 32'(count), 32'd0);
    arm = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b1, 16'(i + 40), 1'b0);
    check("disarm_count", 32'(count), 32'd0);
    check("disarm_dropped", 32'(dropped), 32'd0);

    // Random traffic across modes, clears and occasional resets
    for (int i = 0; i < 3000; i++) begin
      arm   = ($urandom_range(0, 9) != 0);
      mode  = (i / 300) % 2 == 1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      clear = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 299) != 0);
      cyc(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0));
    end
    reset = 1'b1; clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_trace_buf.md
RETIRE_TRACE_BUF -- requirements
Module: retire_trace_buf

Interface
REQ-001 Parameter DATA_W, default 16: width of each captured pc/instruction/result field.
REQ-002 Parameter DEPTH, default 16: number of trace entries; SHALL be a power of two, at least 2.
REQ-003 Parameter AW, default log2(DEPTH): pointer width.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port reset  input  1: synchronous, active-low; the only reset.
REQ-006 Port clear  input  1: synchronous flush of the buffer contents and counters.
REQ-007 Port arm  input  1: capture enable, level-sensitive.
REQ-008 Port mode  input  1: 0 = stop-when-full; 1 = wrap (overwrite oldest entry).
REQ-009 Port retire_valid  input  1: one instruction retired this cycle.
REQ-010 Port retire_pc, retire_ins, retire_res  input  DATA_W each: record of the retiring instruction.
REQ-011 Port rd_req  input  1: pop request for the oldest entry.
REQ-012 Port rd_valid  output  1: rd_pc/rd_ins/rd_res hold a popped entry this cycle.
REQ-013 Port rd_pc, rd_ins, rd_res  output  DATA_W each: popped record.
REQ-014 Port count  output  AW+1: number of stored entries, 0..DEPTH.
REQ-015 Port empty, full  output  1 each: count==0 and count==DEPTH respectively.
REQ-016 Port dropped  output  DATA_W: number of lost records, saturating at all-ones.
REQ-017 Port wrapped  output  1: sticky; set when any entry has been overwritten in wrap mode.

Function
REQ-018 Write condition: retire_valid AND arm; the record is stored at the write pointer as one entry.
REQ-019 Read condition: rd_req AND not empty; the oldest entry is registered onto rd_* and rd_valid is 1 on the next cycle; read latency is exactly 1 cycle.
REQ-020 rd_valid SHALL be 0 in any cycle that does not follow an accepted read; rd_* data SHALL hold its last value when rd_valid is 0.
REQ-021 rd_req while empty: ignored, no pointer change, rd_valid 0 next cycle.
REQ-022 Write only, not full: the entry is stored, the write pointer is incremented modulo DEPTH, and count is incremented.
REQ-023 Write when full, mode=0: the record is discarded, dropped is incremented, and pointers and count are unchanged.
REQ-024 Write when full, mode=1: the record overwrites the oldest entry, both pointers advance, count stays DEPTH, dropped is incremented, and wrapped is set to 1.
REQ-025 Simultaneous write and read when full, either mode: the oldest entry is popped, the new record is stored, count stays DEPTH, and neither dropped nor wrapped changes.
REQ-026 Simultaneous write and read when empty: the write is accepted, the read is ignored, and count becomes 1.
REQ-027 Simultaneous write and read otherwise: both are performed and count is unchanged.
REQ-028 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless; FIFO order SHALL be preserved across any number of wraps.
REQ-029 dropped SHALL saturate at 2^DATA_W-1 and never roll over.
REQ-030 retire_valid while arm=0 SHALL be ignored and SHALL NOT count as dropped.
REQ-031 A change of mode takes effect for writes from the following cycle onwards; stored entries are unaffected.
REQ-032 clear=1: pointers, count, dropped and wrapped go to 0 and rd_valid goes to 0 next cycle; any concurrent write or read is discarded; clear has priority over all operations except reset.

Reset
REQ-033 With reset=0 at a rising edge, the following SHALL be 0: pointers, count, full, dropped, wrapped, rd_valid and rd_*; empty SHALL be 1.
REQ-034 Reset mid-operation SHALL abandon any in-flight read, so that rd_valid is 0 in the cycle after the reset edge; storage array contents need not be cleared.

Verification (DATA_W=16, DEPTH=4)
REQ-035 Arm=1, mode=0, write pc=1..3, then pop three times -> rd_pc 1,2,3 on consecutive cycles, each one cycle after its rd_req; empty=1 at the end.
REQ-036 Arm=1, mode=0, write pc=1..6 -> count=4, full=1, dropped=2, wrapped=0; pops return 1,2,3,4.
REQ-037 Arm=1, mode=1, write pc=1..6 -> count=4, dropped=2, wrapped=1; pops return 3,4,5,6.
REQ-038 Full with entries 1..4, then write pc=9 together with rd_req -> rd_pc=1, count=4, dropped=0; the next four pops return 2,3,4,9.
REQ-039 Write three entries, assert clear together with retire_valid -> count=0, empty=1, dropped=0; a pop the next cycle gives rd_valid=0.
REQ-040 rd_req accepted, then reset=0 on the next edge -> rd_valid=0 and count=0 afterwards; arm=0 with retire_valid pulses -> count and dropped stay 0.
